// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the stopwatch digit chain: button sync/edge detect, 100 Hz prescaler, FSM.
// Optional lap/display-hold feature is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic       start_btn_i,
    input  logic       clear_btn_i,
    input  logic       lap_btn_i,
    output logic       tick_o,
    output logic       clear_o,
    output logic       running_o,
    output logic       hold_o,
    output logic [1:0] state_o
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [PRE_W-1:0] pre, pre_next, pre_inc;
    logic             clear_next;

    logic [1:0] start_sync, clear_sync;
    logic       start_prev, clear_prev;
    logic       start_stb, clear_stb;

    // Strobes are registered, so a press acts three edges after it is first sampled.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            start_sync <= '0;
            clear_sync <= '0;
            start_prev <= 1'b0;
            clear_prev <= 1'b0;
            start_stb  <= 1'b0;
            clear_stb  <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], start_btn_i};
            clear_sync <= {clear_sync[0], clear_btn_i};
            start_prev <= start_sync[1];
            clear_prev <= clear_sync[1];
            start_stb  <= start_sync[1] & ~start_prev;
            clear_stb  <= clear_sync[1] & ~clear_prev;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [1:0] lap_sync;
    logic       lap_prev;
    logic       lap_stb;

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            lap_sync <= '0;
            lap_prev <= 1'b0;
            lap_stb  <= 1'b0;
        end else begin
            lap_sync <= {lap_sync[0], lap_btn_i};
            lap_prev <= lap_sync[1];
            lap_stb  <= lap_sync[1] & ~lap_prev;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap_btn_i;
`endif

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pre     <= '0;
            clear_o <= 1'b0;
        end else begin
            state   <= state_next;
            pre     <= pre_next;
            clear_o <= clear_next;
        end
    end

    assign pre_inc = (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);

    // The prescaler advances off the current state, so a stop on a tick cycle still wraps it.
    always_comb begin
        state_next = state;
        pre_next   = pre;
        clear_next = 1'b0;
        case (state)
            IDLE: begin
                pre_next = '0;
                if (clear_stb) begin
                    clear_next = 1'b1;
                end else if (start_stb) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                pre_next = pre_inc;
                if (start_stb) begin
                    state_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (lap_stb) begin
                    state_next = LAP;
`endif
                end
            end
            PAUSE: begin
                if (clear_stb) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                    pre_next   = '0;
                end else if (start_stb) begin
                    state_next = RUN;
                end
            end
            LAP: begin
`ifdef STOPWATCH_LAP_EN
                pre_next = pre_inc;
                if (start_stb) begin
                    state_next = PAUSE;
                end else if (lap_stb) begin
                    state_next = RUN;
                end
`else
                state_next = IDLE;
                pre_next   = '0;
`endif
            end
            default: begin
                state_next = IDLE;
                pre_next   = '0;
            end
        endcase
    end

    assign running_o = (state == RUN) || (state == LAP);
    assign tick_o    = (pre == PRE_MAX) && running_o;
    assign state_o   = state;

`ifdef STOPWATCH_LAP_EN
    assign hold_o = (state == LAP);
`else
    assign hold_o = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TICK_DIV=4; expected values are hand-computed per scenario.
module tb_stopwatch_ctrl;

    localparam int unsigned TICK_DIV = 4;

    logic       clk100    = 1'b0;
    logic       rst       = 1'b1;
    logic       start_btn = 1'b0;
    logic       clear_btn = 1'b0;
    logic       lap_btn   = 1'b0;
    logic       tick_o, clear_o, running_o, hold_o;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk100_i   (clk100),
        .rst_i      (rst),
        .start_btn_i(start_btn),
        .clear_btn_i(clear_btn),
        .lap_btn_i  (lap_btn),
        .tick_o     (tick_o),
        .clear_o    (clear_o),
        .running_o  (running_o),
        .hold_o     (hold_o),
        .state_o    (state_o)
    );

    always #5 clk100 = ~clk100;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk100);
    endtask

    // Two-cycle press; returns on the negedge right after the resulting state change.
    task automatic applyStimulus(input logic s, input logic c, input logic l);
        start_btn = s;
        clear_btn = c;
        lap_btn   = l;
        cycles(2);
        start_btn = 1'b0;
        clear_btn = 1'b0;
        lap_btn   = 1'b0;
        cycles(2);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        start_btn = 1'b0;
        clear_btn = 1'b0;
        lap_btn   = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_btn = ~start_btn;
            clear_btn = ~clear_btn;
            lap_btn   = ~lap_btn;
            cycles(1);
            obs = {state_o, tick_o, clear_o, running_o, hold_o};
            n_checks++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b expected 000000", i, obs);
            end
        end
        start_btn = 1'b0;
        clear_btn = 1'b0;
        lap_btn   = 1'b0;
        rst       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            obs = {state_o, tick_o, clear_o, running_o, hold_o};
            n_checks++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_release cycle %0d: got %b expected 000000", i, obs);
            end
        end
    endtask

    task automatic test_start_ticks;
        int   tick_count;
        logic exp_tick;
        do_reset();
        tick_count = 0;
        start_btn  = 1'b1;
        for (int n = 1; n <= 43; n++) begin
            cycles(1);
            if (n == 5) start_btn = 1'b0;
            if (n == 3) begin
                n_checks++;
                if (state_o !== 2'd0) begin
                    n_fail++;
                    $display("[TB] FAIL start_latency_early: got %0d expected 0", state_o);
                end
            end
            if (n == 4) begin
                n_checks++;
                if (state_o !== 2'd1 || running_o !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL start_enter_run: got state %0d running %b expected 1 1", state_o, running_o);
                end
            end
            if (n >= 4) begin
                exp_tick = ((n - 4) % 4 == 3);
                if (tick_o === 1'b1) tick_count++;
                n_checks++;
                if (tick_o !== exp_tick) begin
                    n_fail++;
                    $display("[TB] FAIL tick_cadence n=%0d: got %b expected %b", n, tick_o, exp_tick);
                end
            end
        end
        n_checks++;
        if (tick_count != 10 || state_o !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL tick_count: got %0d ticks state %0d expected 10 ticks state 1", tick_count, state_o);
        end
    endtask

    task automatic test_pause_resume;
        logic exp_tick;
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        cycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (state_o !== 2'd2 || running_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pause_enter: got state %0d running %b expected 2 0", state_o, running_o);
        end
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            n_checks++;
            if (tick_o !== 1'b0 || state_o !== 2'd2) begin
                n_fail++;
                $display("[TB] FAIL pause_quiet i=%0d: got tick %b state %0d expected 0 2", i, tick_o, state_o);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (state_o !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL resume_state: got %0d expected 1", state_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycles(1);
            exp_tick = (i == 2);
            n_checks++;
            if (tick_o !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL resume_tick i=%0d: got %b expected %b", i, tick_o, exp_tick);
            end
        end
    endtask

    task automatic test_stop_on_tick;
        logic       exp_tick;
        logic [1:0] exp_state;
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        start_btn = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            cycles(1);
            if (n == 2) start_btn = 1'b0;
            exp_tick  = (n == 3);
            exp_state = (n < 4) ? 2'd1 : 2'd2;
            n_checks++;
            if (tick_o !== exp_tick || state_o !== exp_state) begin
                n_fail++;
                $display("[TB] FAIL stop_on_tick n=%0d: got tick %b state %0d expected %b %0d",
                         n, tick_o, state_o, exp_tick, exp_state);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycles(1);
            exp_tick = (i == 3);
            n_checks++;
            if (tick_o !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL stop_on_tick_resume i=%0d: got %b expected %b", i, tick_o, exp_tick);
            end
        end
    endtask

    task automatic test_clear;
        logic exp_tick;
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state_o !== 2'd0 || clear_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_idle: got state %0d clear %b expected 0 1", state_o, clear_o);
        end
        cycles(1);
        n_checks++;
        if (clear_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_idle_width: got %b expected 0", clear_o);
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state_o !== 2'd1 || clear_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_in_run: got state %0d clear %b expected 1 0", state_o, clear_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycles(1);
            exp_tick = (i == 3);
            n_checks++;
            if (tick_o !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL clear_in_run_tick i=%0d: got %b expected %b", i, tick_o, exp_tick);
            end
        end

        cycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state_o !== 2'd0 || clear_o !== 1'b1 || running_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_in_pause: got state %0d clear %b running %b expected 0 1 0",
                     state_o, clear_o, running_o);
        end
        cycles(1);
        n_checks++;
        if (clear_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_pause_width: got %b expected 0", clear_o);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycles(1);
            exp_tick = (i == 3);
            n_checks++;
            if (tick_o !== exp_tick) begin
                n_fail++;
                $display("[TB] FAIL clear_pre_zero i=%0d: got %b expected %b", i, tick_o, exp_tick);
            end
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (state_o !== 2'd0 || clear_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_clear_pause: got state %0d clear %b expected 0 1", state_o, clear_o);
        end
    endtask

    task automatic test_lap;
        logic exp_tick;
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
        n_checks++;
        if (state_o !== 2'd3 || hold_o !== 1'b1 || running_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL lap_enter: got state %0d hold %b running %b expected 3 1 1",
                     state_o, hold_o, running_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycles(1);
            exp_tick = (i == 3);
            n_checks++;
            if (tick_o !== exp_tick || state_o !== 2'd3) begin
                n_fail++;
                $display("[TB] FAIL lap_tick i=%0d: got tick %b state %0d expected %b 3", i, tick_o, state_o, exp_tick);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (state_o !== 2'd1 || hold_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lap_exit: got state %0d hold %b expected 1 0", state_o, hold_o);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (state_o !== 2'd2 || hold_o !== 1'b0 || running_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lap_to_pause: got state %0d hold %b running %b expected 2 0 0",
                     state_o, hold_o, running_o);
        end
`else
        n_checks++;
        if (state_o !== 2'd1 || hold_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lap_disabled_run: got state %0d hold %b expected 1 0", state_o, hold_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycles(1);
            exp_tick = (i == 3);
            n_checks++;
            if (tick_o !== exp_tick || hold_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL lap_disabled_tick i=%0d: got tick %b hold %b expected %b 0", i, tick_o, hold_o, exp_tick);
            end
        end
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (state_o !== 2'd0 || hold_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lap_disabled_idle: got state %0d hold %b expected 0 0", state_o, hold_o);
        end
`endif
    endtask

    task automatic test_reset_mid_run;
        logic [3:0] obs;
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        obs = {state_o, tick_o, clear_o};
        n_checks++;
        if (obs !== 4'b0 || running_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_run: got %b running %b expected 0000 0", obs, running_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            obs = {state_o, tick_o, clear_o};
            n_checks++;
            if (obs !== 4'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_run_after i=%0d: got %b expected 0000", i, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_pause_resume();
        test_stop_on_tick();
        test_clear();
        test_lap();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
